gate_frame_builder: RTL and testbench

- Upstream feeder for the dynamic gate stage.
- Accepts one signed stereo sample per i_valid strobe from the audio receive path.
- Converts each sample to a saturated magnitude and keeps the sign separately.
- Packs 16 samples into ping-pong frame banks and presents a complete frame (16 L + 16 R magnitudes) to the gate through a valid/ready handshake; the sign vectors go with it for re-signing downstream.

---
 rtl/gate_pkg.sv | 14 +
 rtl/sat_abs.sv | 21 ++
 rtl/gate_frame_builder.sv | 135 +++++++++++++
 tb/tb_gate_frame_builder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared types and constants for the gate frame builder.
// Sample width, frame length and magnitude ceiling live here.
package gate_pkg;

  localparam int DW        = 16;
  localparam int FRAME_LEN = 16;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  typedef logic [DW-1:0] sample_t;
  typedef sample_t frame_t [FRAME_LEN];

  localparam sample_t MAG_MAX = 16'h7FFF;

endpackage

// File: rtl/sat_abs.sv
// Signed sample to saturated magnitude plus sign bit.
// The most negative input clamps to the largest positive value.
module sat_abs #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] x_i,
  output logic [DW-1:0] mag_o,
  output logic          sign_o
);

  logic [DW:0] ext;
  logic [DW:0] abs_v;

  assign ext    = {x_i[DW-1], x_i};
  assign abs_v  = ext[DW] ? -ext : ext;
  assign sign_o = x_i[DW-1];
  assign mag_o  = (abs_v[DW:DW-1] != 2'b00)
                ? {1'b0, {(DW-1){1'b1}}}
                : abs_v[DW-1:0];

endmodule

// File: rtl/gate_frame_builder.sv
// Packs stereo magnitudes into ping-pong frame banks and
// hands complete frames to the gate over valid/ready.
module gate_frame_builder
  import gate_pkg::*;
#(
  parameter int FRAME_LEN = gate_pkg::FRAME_LEN,
  parameter int DW        = gate_pkg::DW
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [DW-1:0]        i_sample_l,
  input  logic [DW-1:0]        i_sample_r,
  input  logic                 i_frame_ready,
  input  logic                 i_clr_ovf,
  output logic                 o_frame_valid,
  output logic [DW-1:0]        o_seq_l [FRAME_LEN],
  output logic [DW-1:0]        o_seq_r [FRAME_LEN],
  output logic [FRAME_LEN-1:0] o_sign_l,
  output logic [FRAME_LEN-1:0] o_sign_r,
  output logic                 o_overflow,
  output logic [15:0]          o_drop_cnt
);

  localparam int IW = $clog2(FRAME_LEN);

  logic [DW-1:0]        mag_l, mag_r;
  logic                 sgn_l, sgn_r;

  logic [DW-1:0]        mag_l_q [2][FRAME_LEN];
  logic [DW-1:0]        mag_r_q [2][FRAME_LEN];
  logic [FRAME_LEN-1:0] sign_l_q [2];
  logic [FRAME_LEN-1:0] sign_r_q [2];

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          accept, drop, hs;

  sat_abs #(.DW(DW)) u_abs_l (
    .x_i    (i_sample_l),
    .mag_o  (mag_l),
    .sign_o (sgn_l)
  );

  sat_abs #(.DW(DW)) u_abs_r (
    .x_i    (i_sample_r),
    .mag_o  (mag_r),
    .sign_o (sgn_r)
  );

  // Free test uses current-state bank_full only
  assign accept = i_valid && !full_q[wr_bank_q];
  assign drop   = i_valid &&  full_q[wr_bank_q];
  assign hs     = valid_q && i_frame_ready;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    if (hs) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (accept) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_idx_q == IW'(FRAME_LEN-1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (i_clr_ovf) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
    valid_d = full_d[rd_bank_d];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < 2; b++) begin
        sign_l_q[b] <= '0;
        sign_r_q[b] <= '0;
        for (int k = 0; k < FRAME_LEN; k++) begin
          mag_l_q[b][k] <= '0;
          mag_r_q[b][k] <= '0;
        end
      end
    end else if (accept) begin
      mag_l_q[wr_bank_q][wr_idx_q]  <= mag_l;
      mag_r_q[wr_bank_q][wr_idx_q]  <= mag_r;
      sign_l_q[wr_bank_q][wr_idx_q] <= sgn_l;
      sign_r_q[wr_bank_q][wr_idx_q] <= sgn_r;
    end
  end

  assign o_frame_valid = valid_q;
  assign o_seq_l       = mag_l_q[rd_bank_q];
  assign o_seq_r       = mag_r_q[rd_bank_q];
  assign o_sign_l      = sign_l_q[rd_bank_q];
  assign o_sign_r      = sign_r_q[rd_bank_q];
  assign o_overflow    = ovf_q;
  assign o_drop_cnt    = cnt_q;

endmodule

// File: tb/tb_gate_frame_builder.sv
// Directed bench for gate_frame_builder.
// Hand-computed vectors cover packing, saturation, drops and reset.
module tb_gate_frame_builder;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [15:0] sl, sr;
  logic        rdy;
  logic        clr;
  logic        fvld;
  logic [15:0] seq_l [16];
  logic [15:0] seq_r [16];
  logic [15:0] sgn_l, sgn_r;
  logic        ovf;
  logic [15:0] dcnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gate_frame_builder dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (vld),
    .i_sample_l    (sl),
    .i_sample_r    (sr),
    .i_frame_ready (rdy),
    .i_clr_ovf     (clr),
    .o_frame_valid (fvld),
    .o_seq_l       (seq_l),
    .o_seq_r       (seq_r),
    .o_sign_l      (sgn_l),
    .o_sign_r      (sgn_r),
    .o_overflow    (ovf),
    .o_drop_cnt    (dcnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int l, input int r);
    vld = 1'b1;
    sl  = 16'(l);
    sr  = 16'(r);
    tick();
    vld = 1'b0;
  endtask

  task automatic handshake();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sl = '0; sr = '0;
    rdy = 1'b0; clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(fvld), 32'd0);
    chk("rst_ovf",   32'(ovf),  32'd0);
    chk("rst_cnt",   32'(dcnt), 32'd0);
    chk("rst_seq",   32'(seq_l[0]), 32'd0);
    chk("rst_sign",  32'(sgn_l), 32'd0);

    // basic frame: L=k-8, R=-k
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("pre16_valid", 32'(fvld), 32'd0);
      send(k - 8, -k);
    end
    chk("f1_valid", 32'(fvld), 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("f1_seql%0d", k), 32'(seq_l[k]),
          32'(k < 8 ? 8 - k : k - 8));
      chk($sformatf("f1_seqr%0d", k), 32'(seq_r[k]), 32'(k));
    end
    chk("f1_signl", 32'(sgn_l), 32'h00FF);
    chk("f1_signr", 32'(sgn_r), 32'hFFFE);
    handshake();
    chk("f1_hs_valid", 32'(fvld), 32'd0);

    // saturation on bank 1
    send(-32768, 32767);
    for (int k = 1; k < 16; k++) send(0, 0);
    chk("sat_valid", 32'(fvld), 32'd1);
    chk("sat_magl", 32'(seq_l[0]), 32'h7FFF);
    chk("sat_magr", 32'(seq_r[0]), 32'h7FFF);
    chk("sat_sgnl", 32'(sgn_l[0]), 32'd1);
    chk("sat_sgnr", 32'(sgn_r[0]), 32'd0);
    handshake();
    chk("sat_hs_valid", 32'(fvld), 32'd0);

    // 40 samples with ready low: 8 dropped
    for (int i = 0; i < 40; i++) send(100 + i, -(200 + i));
    chk("ovr_cnt",   32'(dcnt), 32'd8);
    chk("ovr_flag",  32'(ovf),  32'd1);
    chk("ovr_valid", 32'(fvld), 32'd1);
    chk("ovr_b0_0",  32'(seq_l[0]),  32'd100);
    chk("ovr_b0_15", 32'(seq_r[15]), 32'd215);
    chk("ovr_b0_sr", 32'(sgn_r), 32'hFFFF);
    handshake();
    chk("ovr_b1_valid", 32'(fvld), 32'd1);
    chk("ovr_b1_0",  32'(seq_l[0]),  32'd116);
    chk("ovr_b1_15", 32'(seq_l[15]), 32'd131);

    // completion on bank 0 with handshake of bank 1
    for (int i = 0; i < 15; i++) send(500 + i, 0);
    chk("co_pre_valid", 32'(fvld), 32'd1);
    chk("co_pre_seq", 32'(seq_l[0]), 32'd116);
    rdy = 1'b1;
    send(515, 0);
    rdy = 1'b0;
    chk("co_valid", 32'(fvld), 32'd1);
    chk("co_seq0",  32'(seq_l[0]),  32'd500);
    chk("co_seq15", 32'(seq_l[15]), 32'd515);
    handshake();
    chk("co_hs_valid", 32'(fvld), 32'd0);

    // clear coincident with drop
    for (int i = 0; i < 32; i++) send(i, i);
    chk("clr_pre_cnt", 32'(dcnt), 32'd8);
    clr = 1'b1;
    send(7, 7);
    clr = 1'b0;
    chk("clr_ovf", 32'(ovf),  32'd0);
    chk("clr_cnt", 32'(dcnt), 32'd0);
    send(7, 7);
    chk("drop_cnt1", 32'(dcnt), 32'd1);
    chk("drop_ovf1", 32'(ovf),  32'd1);
    // handshake frees the write bank this cycle: still a drop
    rdy = 1'b1;
    send(7, 7);
    rdy = 1'b0;
    chk("hsdrop_cnt",   32'(dcnt), 32'd2);
    chk("hsdrop_valid", 32'(fvld), 32'd1);

    // reset mid-frame
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) send(900 + i, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_valid", 32'(fvld), 32'd0);
    chk("mr_cnt",   32'(dcnt), 32'd0);
    for (int i = 0; i < 16; i++) send(1000 + i, -(1000 + i));
    chk("mr_f_valid", 32'(fvld), 32'd1);
    chk("mr_f_seq0",  32'(seq_l[0]),  32'd1000);
    chk("mr_f_seq15", 32'(seq_r[15]), 32'd1015);
    chk("mr_f_sgnr",  32'(sgn_r), 32'hFFFF);
    chk("mr_f_cnt",   32'(dcnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
